// File: rtl/aes_pkg.sv
// Shared AES-192 definitions for the key-schedule blocks.
// Holds the schedule constants, the word and FSM state types, the round
// constant helper and the forward S-box table with its lookup helper.
package aes_pkg;

  localparam int NK        = 32'sd6;   // words per 192-bit key
  localparam int NR        = 32'sd12;  // rounds
  localparam int FWD_STEPS = 32'sd8;   // 192-bit expansion steps to reach S8

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FWD  = 3'd1,
    ST_INIT = 3'd2,
    ST_EMIT = 3'd3,
    ST_STEP = 3'd4
  } state_t;

  // S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] rcon(input logic [2:0] n);
    return 8'h01 << n;
  endfunction

  // Entry a sits at bit offset 8*(255-a) = {~a, 3'b000}.
  function automatic logic [7:0] sbox_lookup(input logic [7:0] a);
    return SBOX_TABLE[{~a, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ShiftRows.sv
// Word rotation used by the key schedule (RotWord): rotate left by one byte.
// Ports: word_in, word_out.
module ShiftRows
  import aes_pkg::*;
(
  input  word_t word_in,
  output word_t word_out
);
  assign word_out = {word_in[23:0], word_in[31:24]};
endmodule

// File: rtl/keyExpansion192.sv
// One forward AES-192 key expansion step S_k -> S_{k+1}.
// Ports: key_in (S_k, w0 in [191:160]), rCon ({rc,24'h0}), key_out (S_{k+1}).
module keyExpansion192
  import aes_pkg::*;
(
  input  logic [191:0] key_in,
  input  logic [31:0]  rCon,
  output logic [191:0] key_out
);
  word_t rot_s, sub_s, w0_s, w1_s, w2_s, w3_s, w4_s, w5_s;

  ShiftRows u_rot (.word_in(key_in[31:0]), .word_out(rot_s));

  for (genvar i = 0; i < 4; i++) begin : g_sub
    sbox u_sbox (.a(rot_s[8*i +: 8]), .y(sub_s[8*i +: 8]));
  end

  assign w0_s = key_in[191:160] ^ sub_s ^ rCon;
  assign w1_s = w0_s ^ key_in[159:128];
  assign w2_s = w1_s ^ key_in[127:96];
  assign w3_s = w2_s ^ key_in[95:64];
  assign w4_s = w3_s ^ key_in[63:32];
  assign w5_s = w4_s ^ key_in[31:0];
  assign key_out = {w0_s, w1_s, w2_s, w3_s, w4_s, w5_s};
endmodule

// File: rtl/key_inv_step192.sv
// One inverse AES-192 key expansion step S_{k+1} -> S_k.
// Words 1..5 unwind by XOR with their left neighbour; word 0 then needs the
// recovered w5 for its SubWord(RotWord()) term.
// Ports: key_next (S_{k+1}), rCon ({rc,24'h0} used when S_k was advanced),
//        key_prev (S_k).
module key_inv_step192
  import aes_pkg::*;
(
  input  logic [191:0] key_next,
  input  logic [31:0]  rCon,
  output logic [191:0] key_prev
);
  word_t p0_s, p1_s, p2_s, p3_s, p4_s, p5_s, rot_s, sub_s;

  assign p5_s = key_next[31:0]    ^ key_next[63:32];
  assign p4_s = key_next[63:32]   ^ key_next[95:64];
  assign p3_s = key_next[95:64]   ^ key_next[127:96];
  assign p2_s = key_next[127:96]  ^ key_next[159:128];
  assign p1_s = key_next[159:128] ^ key_next[191:160];

  ShiftRows u_rot (.word_in(p5_s), .word_out(rot_s));

  for (genvar i = 0; i < 4; i++) begin : g_sub
    sbox u_sbox (.a(rot_s[8*i +: 8]), .y(sub_s[8*i +: 8]));
  end

  assign p0_s = key_next[191:160] ^ sub_s ^ rCon;
  assign key_prev = {p0_s, p1_s, p2_s, p3_s, p4_s, p5_s};
endmodule

// File: rtl/sbox.sv
// AES forward S-box, one byte.
// Ports: a (byte in), y (substituted byte out).
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = sbox_lookup(a);
endmodule

// File: rtl/aes192_inv_key_sched.sv
// Iterative AES-192 decryption key scheduler.
// Expands the cipher key forward to S8, then walks back through the schedule
// emitting RK12 down to RK0 on a valid/ready stream.
// Ports: clk, rst (async, active high); key_in/key_valid/key_ready accept a
// key in IDLE; rk_data/rk_index/rk_last/rk_valid/rk_ready carry round keys;
// busy is high outside IDLE.  All outputs are registered.
module aes192_inv_key_sched
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [191:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_index,
  output logic         rk_last,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy
);
  state_t       state_r;
  logic [191:0] hi_r, lo_r;       // window {lo,hi} = words 6k..6k+11
  logic [2:0]   k_r, fcnt_r;
  logic [3:0]   r_r;

  logic [191:0] fwd_s, inv_src_s, inv_s;
  logic [31:0]  inv_rc_s;
  logic [3:0]   r_m1_s;
  logic         step_due_s;

  // Round key r is window words (4r-6k)..(4r-6k+3).
  function automatic logic [127:0] win_sel(input logic [383:0] win,
                                           input logic [3:0] r,
                                           input logic [2:0] k);
    logic [5:0]   off;
    logic [383:0] sh;
    off = {r, 2'b00} - 6'(32'(k) * NK);
    sh  = win << {off, 5'b00000};
    return sh[383:256];
  endfunction

  keyExpansion192 u_fwd (
    .key_in (hi_r),
    .rCon   ({rcon(fcnt_r), 24'h000000}),
    .key_out(fwd_s)
  );

  key_inv_step192 u_inv (
    .key_next(inv_src_s),
    .rCon    (inv_rc_s),
    .key_prev(inv_s)
  );

  // INIT unwinds S8 (in hi) with rc=0x80; STEP unwinds lo with rc for k-1.
  always_comb begin
    inv_src_s = lo_r;
    inv_rc_s  = {rcon(k_r - 3'd1), 24'h000000};
    if (state_r == ST_INIT) begin
      inv_src_s = hi_r;
      inv_rc_s  = {rcon(3'd7), 24'h000000};
    end else begin
      inv_src_s = lo_r;
      inv_rc_s  = {rcon(k_r - 3'd1), 24'h000000};
    end
  end

  assign r_m1_s = r_r - 4'd1;
  // Next key starts below the window: slide it down one 192-bit state.
  assign step_due_s = ({r_m1_s, 2'b00} < 6'(32'(k_r) * NK));

  // Control FSM, schedule registers and registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      hi_r      <= 192'd0;
      lo_r      <= 192'd0;
      k_r       <= 3'd0;
      fcnt_r    <= 3'd0;
      r_r       <= 4'd0;
      rk_valid  <= 1'b0;
      rk_last   <= 1'b0;
      rk_data   <= 128'd0;
      rk_index  <= 4'd0;
      busy      <= 1'b0;
      key_ready <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (key_valid) begin
            hi_r      <= key_in;
            fcnt_r    <= 3'd0;
            state_r   <= ST_FWD;
            key_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_FWD: begin
          hi_r   <= fwd_s;
          fcnt_r <= fcnt_r + 3'd1;
          if (fcnt_r == 3'(FWD_STEPS - 1)) begin
            state_r <= ST_INIT;
          end
        end
        ST_INIT: begin
          lo_r     <= inv_s;
          k_r      <= 3'd7;
          r_r      <= 4'(NR);
          state_r  <= ST_EMIT;
          rk_valid <= 1'b1;
          rk_data  <= win_sel({inv_s, hi_r}, 4'(NR), 3'd7);
          rk_index <= 4'(NR);
          rk_last  <= 1'b0;
        end
        ST_EMIT: begin
          if (rk_ready) begin
            if (r_r == 4'd0) begin
              state_r   <= ST_IDLE;
              rk_valid  <= 1'b0;
              rk_last   <= 1'b0;
              rk_data   <= 128'd0;
              rk_index  <= 4'd0;
              busy      <= 1'b0;
              key_ready <= 1'b1;
            end else begin
              r_r <= r_m1_s;
              if (step_due_s) begin
                state_r  <= ST_STEP;
                rk_valid <= 1'b0;
              end else begin
                rk_data  <= win_sel({lo_r, hi_r}, r_m1_s, k_r);
                rk_index <= r_m1_s;
                rk_last  <= (r_m1_s == 4'd0);
              end
            end
          end
        end
        ST_STEP: begin
          hi_r     <= lo_r;
          lo_r     <= inv_s;
          k_r      <= k_r - 3'd1;
          state_r  <= ST_EMIT;
          rk_valid <= 1'b1;
          rk_data  <= win_sel({inv_s, lo_r}, r_r, k_r - 3'd1);
          rk_index <= r_r;
          rk_last  <= (r_r == 4'd0);
        end
        default: begin
          state_r   <= ST_IDLE;
          rk_valid  <= 1'b0;
          rk_last   <= 1'b0;
          busy      <= 1'b0;
          key_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes192_inv_key_sched.sv
// Self-checking bench for aes192_inv_key_sched.  The reference is a plain
// FIPS-197 key expansion over an array of words, with the S-box derived
// from GF(2^8) inversion plus the affine map.
module tb_aes192_inv_key_sched;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [191:0] key_in = 192'd0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;
  logic         rk_last, rk_valid;
  logic         rk_ready = 1'b0;
  logic         busy;

  int checks = 0, failures = 0, cyc = 0;
  logic [7:0]   sb [256];
  logic [127:0] exp_rk [13];
  logic [7:0]   inv_b;

  typedef struct {
    logic [191:0] key;
    logic [127:0] rk12;
    logic [127:0] rk0;
  } vec_t;
  vec_t vecs [2];

  aes192_inv_key_sched dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .rk_data(rk_data), .rk_index(rk_index),
    .rk_last(rk_last), .rk_valid(rk_valid), .rk_ready(rk_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_idle(input string nm);
    chk(nm, 192'({rk_valid, rk_last, busy, key_ready, rk_index, rk_data}),
        192'({1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 128'd0}));
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [191:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Textbook AES-192 key expansion; exp_rk[r] = {w[4r]..w[4r+3]}.
  task automatic model_expand(input logic [191:0] key);
    logic [31:0] w [54];
    logic [31:0] t;
    for (int i = 0; i < 6; i++) w[i] = key[191 - 32*i -: 32];
    for (int i = 6; i < 54; i++) begin
      t = w[i-1];
      if (i % 6 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]}
            ^ {8'h01 << (i/6 - 1), 24'h000000};
      end
      w[i] = w[i-6] ^ t;
    end
    for (int r = 0; r < 13; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic accept_key(input logic [191:0] key, output int t);
    for (int n = 0; n < 100 && !key_ready; n++) tick();
    chk("accept_ready", 192'(key_ready), 192'd1);
    key_in = key;
    key_valid = 1'b1;
    t = cyc;
    tick();
    key_valid = 1'b0;
  endtask

  // Consume one full stream, checking order, data, last flag and stall hold.
  task automatic collect(input logic [191:0] key, input bit rnd,
                         output int t_first, output int t_last,
                         output logic [127:0] d_first, output logic [127:0] d_last);
    int idx;
    bit held, stable_ok, busy_ok;
    logic [127:0] hd;
    logic [3:0] hx;
    logic hl;
    model_expand(key);
    idx = 12; held = 0; stable_ok = 1; busy_ok = 1;
    t_first = -1; t_last = -1; d_first = '0; d_last = '0; hd = '0; hx = '0; hl = 1'b0;
    for (int n = 0; n < 400 && idx >= 0; n++) begin
      rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held && !(rk_valid && rk_data == hd && rk_index == hx && rk_last == hl)) stable_ok = 0;
      if (!busy || key_ready) busy_ok = 0;
      if (rk_valid && t_first < 0) begin
        t_first = cyc;
        d_first = rk_data;
      end
      if (rk_valid && rk_ready) begin
        chk($sformatf("rk_data[%0d]", idx), 192'(rk_data), 192'(exp_rk[idx]));
        chk($sformatf("rk_index[%0d]", idx), 192'(rk_index), 192'(idx));
        chk($sformatf("rk_last[%0d]", idx), 192'(rk_last), 192'(idx == 0));
        if (idx == 0) begin
          t_last = cyc;
          d_last = rk_data;
        end
        idx--;
        held = 0;
      end else if (rk_valid) begin
        held = 1; hd = rk_data; hx = rk_index; hl = rk_last;
      end else begin
        held = 0;
      end
      tick();
    end
    chk("stream_complete", 192'(idx), 192'(-1));
    chk("stall_stable", 192'(stable_ok), 192'd1);
    chk("busy_in_stream", 192'(busy_ok), 192'd1);
    rk_ready = 1'b0;
  endtask

  initial begin
    int t, t2, tf, tl;
    logic [127:0] df, dl;
    bit quiet;

    for (int a = 0; a < 256; a++) begin
      inv_b = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv_b = 8'(b);
      sb[a] = inv_b ^ rotl8(inv_b, 1) ^ rotl8(inv_b, 2) ^ rotl8(inv_b, 3) ^ rotl8(inv_b, 4) ^ 8'h63;
    end

    vecs[0] = '{key:  192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                rk12: 128'he98ba06f448c773c8ecc720401002202,
                rk0:  128'h8e73b0f7da0e6452c810f32b809079e5};
    vecs[1] = '{key:  192'h000102030405060708090a0b0c0d0e0f1011121314151617,
                rk12: 128'ha4970a331a78dc09c418c271e3a41d5d,
                rk0:  128'h000102030405060708090a0b0c0d0e0f};

    // Reset state, during and after reset.
    tick(); tick(); tick();
    check_idle("reset_hold");
    rst = 1'b0;
    tick();
    check_idle("reset_release");

    // Known-answer vectors with rk_ready held high: exact latency.
    for (int v = 0; v < 2; v++) begin
      accept_key(vecs[v].key, t);
      quiet = 1;
      for (int n = 0; n < 9; n++) begin
        if (rk_valid || !busy) quiet = 0;
        tick();
      end
      chk("fwd_quiet", 192'(quiet), 192'd1);
      collect(vecs[v].key, 1'b0, tf, tl, df, dl);
      chk("kat_rk12", 192'(df), 192'(vecs[v].rk12));
      chk("kat_rk0", 192'(dl), 192'(vecs[v].rk0));
      chk("rk12_latency", 192'(tf - t), 192'd10);
      chk("rk0_latency", 192'(tl - t), 192'd29);
      chk("idle_after", 192'({key_ready, busy}), 192'(2'b10));
    end

    // Random back-pressure on the incrementing key.
    accept_key(vecs[1].key, t);
    collect(vecs[1].key, 1'b1, tf, tl, df, dl);
    chk("stall_rk12", 192'(df), 192'(vecs[1].rk12));

    // key_valid held through a run: second key only at T+30.
    key_in = vecs[0].key;
    key_valid = 1'b1;
    t = cyc;
    tick();
    key_in = vecs[1].key;
    collect(vecs[0].key, 1'b0, tf, tl, df, dl);
    chk("hold_rk0_time", 192'(tl - t), 192'd29);
    chk("hold_ready_t30", 192'({cyc - t == 30, key_ready}), 192'(2'b11));
    t2 = cyc;
    tick();
    key_valid = 1'b0;
    collect(vecs[1].key, 1'b0, tf, tl, df, dl);
    chk("hold_second_rk12", 192'(tf - t), 192'd40);
    chk("hold_second_data", 192'(df), 192'(vecs[1].rk12));

    // Reset pulse in the STEP bubble between RK9 and RK8.
    accept_key(vecs[0].key, t);
    rk_ready = 1'b1;
    for (int n = 0; n < 40 && cyc < t + 15; n++) tick();
    chk("step_bubble", 192'({cyc - t == 15, rk_valid, busy}), 192'(3'b101));
    #2 rst = 1'b1;
    #1 check_idle("rst_in_step");
    tick();
    rst = 1'b0;
    quiet = 1;
    for (int n = 0; n < 12; n++) begin
      if (rk_valid || !key_ready) quiet = 0;
      tick();
    end
    chk("no_resume_step", 192'(quiet), 192'd1);
    df = 128'd0;
    begin
      logic [191:0] rk;
      rk = rand_key();
      accept_key(rk, t);
      collect(rk, 1'b0, tf, tl, df, dl);
      chk("after_rst_latency", 192'(tf - t), 192'd10);
    end

    // Reset pulse during FWD at fcnt=4, then back-to-back random keys.
    accept_key(rand_key(), t);
    for (int n = 0; n < 20 && cyc < t + 5; n++) tick();
    #2 rst = 1'b1;
    #1 check_idle("rst_in_fwd");
    tick();
    rst = 1'b0;
    quiet = 1;
    for (int n = 0; n < 15; n++) begin
      if (rk_valid || busy) quiet = 0;
      tick();
    end
    chk("no_resume_fwd", 192'(quiet), 192'd1);
    for (int j = 0; j < 3; j++) begin
      logic [191:0] rk;
      rk = rand_key();
      accept_key(rk, t);
      collect(rk, 1'b1, tf, tl, df, dl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes192_inv_key_sched.md
# aes192_inv_key_sched

- Iterative AES-192 decryption key scheduler: accepts a 192-bit cipher key and emits the 13 round keys in reverse order, RK12 first and RK0 last, over a valid/ready stream.
- Runs the forward 192-bit expansion step 8 times to reach the final schedule state, then walks backwards one 192-bit state at a time through the inverse step.
- It is the inverse-direction companion of the forward key expansion and feeds the inverse-cipher round datapath.

## Interface
- No parameters; AES-192 only (Nk=6, Nr=12).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_in  in  192  cipher key. w0 is in [191:160] and w5 in [31:0].
- key_valid  in  1  key_in is valid.
- key_ready  out  1  high only in IDLE. A key is accepted when key_valid && key_ready.
- rk_data  out  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in [127:96].
- rk_index  out  4  round number r of rk_data (12 down to 0).
- rk_last  out  1  high with rk_valid when r=0.
- rk_valid  out  1  round key is presented.
- rk_ready  in  1  consumer accepts. A transfer is rk_valid && rk_ready.
- busy  out  1  high in every state except IDLE.

## Operation
- Schedule words are w0..w53. State S_k = w[6k..6k+5].
- Forward step S_k→S_{k+1} (existing step):
  - w'0 = w0 ^ SubWord(RotWord(w5)) ^ {rc,24'h0}
  - w'i = w'(i-1) ^ wi, for i = 1..5
  - rc = 8'h01 << k
- Inverse step S_{k+1}→S_k:
  - wi = w'i ^ w'(i-1), for i = 5 down to 1
  - w0 = w'0 ^ SubWord(RotWord(w5)) ^ {8'h01<<k, 24'h0}, using the recovered w5
- Registers:
  - hi, lo: 192 bits each. The window {lo,hi} covers words 6k..6k+11.
  - k: 3 bits.
  - fcnt: 3 bits.
  - r: 4 bits.
- FSM states:
  - IDLE: key_ready=1. On accept, hi←key_in, fcnt←0, go to FWD.
  - FWD: hi←fwd(hi, rc=1<<fcnt), fcnt++. After the 8th step, hi=S8; go to INIT.
  - INIT: lo←inv(hi, rc=8'h80), k←7, r←12, go to EMIT.
  - EMIT: rk_valid=1, rk_data = window words (4r−6k)..(4r−6k+3).
    - On transfer with r=0: go to IDLE.
    - On transfer with r>0: r←r−1. If 4(r−1) < 6k, go to STEP, else stay in EMIT.
  - STEP: hi←lo, lo←inv(lo, rc=1<<(k−1)), k←k−1, go to EMIT.
- Step points, in emission order: after RK11 (k→6), RK9 (→5), RK8 (→4), RK6 (→3), RK5 (→2), RK3 (→1), RK2 (→0).
- rk_valid stays high until a transfer. rk_data, rk_index and rk_last hold stable while rk_valid=1 && !rk_ready.
- key_valid is ignored while busy. A new key is never accepted in the cycle RK0 is transferred.
- Reset, async at any time including mid-stream:
  - State→IDLE; hi, lo, k, fcnt, r→0.
  - rk_valid=0, rk_last=0, rk_data=0, rk_index=0, busy=0, key_ready=1 while rst is high and after release.
  - No partial stream resumes.

## Timing
- Key accepted at the edge ending cycle T.
- FWD occupies T+1..T+8, INIT occupies T+9, and the first rk_valid (RK12) appears at T+10.
- With rk_ready held at 1: 13 EMIT cycles plus 7 STEP bubbles, so RK0 transfers at T+29.
- In IDLE the cycle after the RK0 transfer: key_ready=1 at T+30, busy=0.
- Each consumer stall extends the stream cycle-for-cycle. STEP always costs exactly one bubble, with rk_valid=0.

## Structure
- Shared package aes_pkg holds:
  - the AES-192 constants NK=6, NR=12, FWD_STEPS=8;
  - a word type (32 bits);
  - the rcon function 8'h01<<n.
- The forward step instantiates the existing keyExpansion192 unchanged.
- One new combinational sub-module, key_inv_step192 (ports key_next[191:0], rCon[31:0], key_prev[191:0]), reuses the existing ShiftRows (rotate-by-1) and sbox instances.
- FSM, counters and window mux live in the top module.

## Test plan
- FIPS-197 A.2 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, rk_ready=1:
  - RK12 = e98ba06f448c773c8ecc720401002202 at T+10;
  - RK0 = 8e73b0f7da0e6452c810f32b809079e5 with rk_last=1 at T+29;
  - all 13 keys match the FIPS-197 schedule;
  - rk_index counts 12..0.
- Key 000102…1617 with random rk_ready (50%): same 13 keys as a software model, data stable during stalls, no duplicates or drops.
- key_valid held high through a whole run: exactly one key accepted. The second key is accepted only at T+30, and its RK12 appears 10 cycles later.
- rst pulsed during the STEP between RK9 and RK8: all outputs 0, key_ready=1 immediately. A new key afterwards streams correctly from RK12.
- rst pulsed during FWD (fcnt=4): returns to IDLE with no rk_valid. Back-to-back keys then produce correct independent streams.
